// File: rtl/mult_pkg.sv
// Shared types and default widths for the multiply/accumulate datapath.
package mult_pkg;

  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_LEN_W  = 8;

  localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Job control, product input stream and result output stream of product_accumulator.
interface product_accumulator_if
  import mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              overflow;
  logic              busy;

  modport master (
    output start, len, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, overflow, busy
  );

  modport slave (
    input  start, len, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, overflow, busy
  );

endinterface

// File: rtl/acc_reg_sat.sv
// ACC_W accumulator register with carry-out detect.
// Build option ACC_SATURATE_EN: clamp to all-ones on carry instead of wrapping.
module acc_reg_sat
  import mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  acc,
  output logic              carry
);

  logic [ACC_W:0] sum;

  assign sum   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
  assign carry = sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
`ifdef ACC_SATURATE_EN
      // once clamped, any further nonzero addend carries again, so acc stays at max
      if (carry) acc <= '1;
      else       acc <= sum[ACC_W-1:0];
`else
      acc <= sum[ACC_W-1:0];
`endif
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN unsigned products per job and presents the total on a valid/ready result port.
// Build option ACC_SATURATE_EN (in acc_reg_sat) selects saturating instead of wrapping sums.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start; len sampled here
  // ACCUM | accepting products until len have been taken
  // HOLD  | result presented until out_ready

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             ovf_q;
  logic             xfer;
  logic             last;
  logic             acc_clr;
  logic             carry;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             busy_c;
  logic [ACC_W-1:0] acc;

  assign xfer = (state == ACCUM) && bus.in_valid;
  assign last = (cnt == (len_q - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    acc_clr     = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          acc_clr   = 1'b1;
          state_nxt = (bus.len != '0) ? ACCUM : HOLD;
        end
      end
      ACCUM: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (acc_clr) begin
      len_q <= bus.len;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (xfer) begin
      cnt <= cnt + LEN_W'(1);
      if (carry) ovf_q <= 1'b1;
    end
  end

  acc_reg_sat #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .add_en (xfer),
    .addend (bus.in_product),
    .acc    (acc),
    .carry  (carry)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_sum   = acc;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed-vector bench for product_accumulator (24-bit default and 20-bit overflow instances).
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) bus ();
  product_accumulator_if #(.PROD_W(16), .ACC_W(20), .LEN_W(8)) b20 ();

  product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  product_accumulator #(.PROD_W(16), .ACC_W(20), .LEN_W(8)) dut20 (
    .clk (clk),
    .rst (rst),
    .bus (b20)
  );

  typedef struct {
    int len;
    int p;
    int step;
    int gap;
    int stall;
    bit poke;
    int exp_sum;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input vec_t v);
    int guard;
    bus.start = 1'b1;
    bus.len   = 8'(v.len);
    tick();
    bus.start = v.poke;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    if (v.len == 0) chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < v.len; i++) begin
      for (int g = 0; g < v.gap; g++) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid   = 1'b1;
      bus.in_product = 16'(v.p + i * v.step);
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (!bus.in_ready) begin
        chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("out_valid_latency", 32'(bus.out_valid), 32'd1);
    for (int s = 0; s < v.stall; s++) begin
      tick();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_sum", 32'(bus.out_sum), 32'(v.exp_sum));
    end
    bus.start = 1'b0;
    chk("result_sum", 32'(bus.out_sum), 32'(v.exp_sum));
    chk("result_ovf", 32'(bus.overflow), 32'(v.exp_ovf));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp20_sum;
    vec_t v;

    vecs[0] = '{len: 4,   p: 65025, step: 0, gap: 0, stall: 0, poke: 1'b0, exp_sum: 260100,   exp_ovf: 1'b0};
    vecs[1] = '{len: 3,   p: 1,     step: 1, gap: 2, stall: 5, poke: 1'b1, exp_sum: 6,        exp_ovf: 1'b0};
    vecs[2] = '{len: 0,   p: 0,     step: 0, gap: 0, stall: 1, poke: 1'b0, exp_sum: 0,        exp_ovf: 1'b0};
    vecs[3] = '{len: 255, p: 65025, step: 0, gap: 0, stall: 0, poke: 1'b0, exp_sum: 16581375, exp_ovf: 1'b0};
    vecs[4] = '{len: 2,   p: 65535, step: 0, gap: 1, stall: 2, poke: 1'b0, exp_sum: 131070,   exp_ovf: 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_product = '0; bus.out_ready = 1'b0;
    b20.start = 1'b0; b20.len = '0; b20.in_valid = 1'b0; b20.in_product = '0; b20.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) run_job(vecs[k]);

    // 20-bit instance: 17 * 65025 exceeds 2^20
`ifdef ACC_SATURATE_EN
    exp20_sum = 32'hFFFFF;
`else
    exp20_sum = 56849;
`endif
    b20.start = 1'b1;
    b20.len   = 8'd17;
    tick();
    b20.start      = 1'b0;
    b20.in_valid   = 1'b1;
    b20.in_product = 16'd65025;
    for (int i = 0; i < 17; i++) begin
      if (!b20.in_ready) chk("ovf_in_ready", 32'(b20.in_ready), 32'd1);
      tick();
    end
    b20.in_valid = 1'b0;
    chk("ovf_out_valid", 32'(b20.out_valid), 32'd1);
    chk("ovf_sum", 32'(b20.out_sum), 32'(exp20_sum));
    chk("ovf_flag", 32'(b20.overflow), 32'd1);
    b20.out_ready = 1'b1;
    tick();
    b20.out_ready = 1'b0;
    chk("ovf_out_valid_drop", 32'(b20.out_valid), 32'd0);
    tick();

    // reset after two accepts of a len=4 job
    bus.start = 1'b1;
    bus.len   = 8'd4;
    tick();
    bus.start      = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_product = 16'd100;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_sum", 32'(bus.out_sum), 32'd0);
    repeat (3) begin
      tick();
      chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
    end
    v = '{len: 1, p: 7, step: 0, gap: 0, stall: 0, poke: 1'b0, exp_sum: 7, exp_ovf: 1'b0};
    run_job(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
